// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: state enum, opcode classes
// and datapath mux-select values.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    FAULT    = 4'd10
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [1:0] SRCA_REG   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // States in which the FSM waits on MemReady and the timeout applies.
  function automatic logic is_wait_state(input state_t st);
    return (st == FETCH) || (st == MEMREAD) || (st == MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_wait_timer.sv
// Saturating not-ready cycle counter; expired marks the last tolerated
// not-ready cycle of a memory wait.
module wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_MAX - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(WAIT_MAX);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [CW-1:0] count_r;

  // Count not-ready cycles, saturating at WAIT_MAX so it never wraps.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_r <= '0;
    end else if (en && (count_r != MAX_CNT)) begin
      count_r <= count_r + ONE_CNT;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST_CNT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle processor control FSM: sequences fetch/decode/execute and drives
// datapath strobes, with a memory-wait timeout that traps into FAULT.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic       Imm,
  input  logic       Load,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       Fault,
  output logic [3:0] State
);

  state_t state_r;
  state_t next_state_s;
  logic   expired_s;
  logic   timer_clr_s;
  logic   timer_en_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a wait state times out only while MemReady is low.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FETCH: begin
        if (MemReady)       next_state_s = DECODE;
        else if (expired_s) next_state_s = FAULT;
        else                next_state_s = FETCH;
      end
      DECODE: begin
        case (Op)
          OP_DP:   next_state_s = Imm ? EXECI : EXECR;
          OP_MEM:  next_state_s = MEMADR;
          OP_BR:   next_state_s = BRANCH;
          default: next_state_s = FAULT;
        endcase
      end
      MEMADR:  next_state_s = Load ? MEMREAD : MEMWRITE;
      MEMREAD: begin
        if (MemReady)       next_state_s = MEMWB;
        else if (expired_s) next_state_s = FAULT;
        else                next_state_s = MEMREAD;
      end
      MEMWB:    next_state_s = FETCH;
      MEMWRITE: begin
        if (MemReady)       next_state_s = FETCH;
        else if (expired_s) next_state_s = FAULT;
        else                next_state_s = MEMWRITE;
      end
      EXECR, EXECI:  next_state_s = ALUWB;
      ALUWB, BRANCH: next_state_s = FETCH;
      FAULT:         next_state_s = FAULT;
      default:       next_state_s = FAULT;
    endcase
  end

  // Counter restarts whenever a wait state is freshly entered.
  assign timer_clr_s = is_wait_state(next_state_s) && (next_state_s != state_r);
  assign timer_en_s  = is_wait_state(state_r) && !MemReady;

  wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr_s),
    .en      (timer_en_s),
    .expired (expired_s)
  );

  // Output decode: Moore per state, except the FETCH strobes gated by MemReady.
  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    ALUSrcA   = SRCA_REG;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    Fault     = 1'b0;
    case (state_r)
      FETCH: begin
        IRWrite   = MemReady;
        NextPC    = MemReady;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      MEMADR:  ALUSrcB = SRCB_IMM;
      MEMREAD: AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECR: ALUOp = 1'b1;
      EXECI: begin
        ALUOp   = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ALUWB: RegW = 1'b1;
      BRANCH: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        Branch    = 1'b1;
      end
      FAULT:   Fault = 1'b1;
      default: Fault = 1'b1;
    endcase
  end

  assign State = state_r;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: per-cycle stimulus and expected
// outputs are queued together, then replayed and compared one cycle at a time.
module tb_multicycle_ctrl_fsm;

  localparam int WAIT_MAX = 15;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5,
                         S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
                         S_BRANCH = 4'd9, S_FAULT = 4'd10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic       Imm = 1'b0, Load = 1'b0, MemReady = 1'b0;
  logic       IRWrite, NextPC, AdrSrc, RegW, MemW, Branch, ALUOp, Fault;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;

  typedef struct packed {
    logic [3:0] st;
    logic irw, npc, adr, regw, memw, br, aluop;
    logic [1:0] sa, sb, rs;
    logic flt;
  } obs_t;

  typedef struct packed {
    logic rst;
    logic [1:0] op;
    logic imm, ld, mr;
  } stim_t;

  stim_t stim_q[$];
  obs_t  exp_q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Imm(Imm), .Load(Load), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .Fault(Fault), .State(State)
  );

  // Expected outputs for a state, straight from the state output table.
  function automatic obs_t moore(input logic [3:0] st, input logic mr);
    obs_t o;
    o = '0;
    o.st = st;
    case (st)
      S_FETCH:    begin o.irw = mr; o.npc = mr; o.sa = 2'b01; o.sb = 2'b10; o.rs = 2'b10; end
      S_DECODE:   begin o.sa = 2'b01; o.sb = 2'b10; o.rs = 2'b10; end
      S_MEMADR:   o.sb = 2'b01;
      S_MEMREAD:  o.adr = 1'b1;
      S_MEMWB:    begin o.rs = 2'b01; o.regw = 1'b1; end
      S_MEMWRITE: begin o.adr = 1'b1; o.memw = 1'b1; end
      S_EXECR:    o.aluop = 1'b1;
      S_EXECI:    begin o.aluop = 1'b1; o.sb = 2'b01; end
      S_ALUWB:    o.regw = 1'b1;
      S_BRANCH:   begin o.sa = 2'b10; o.sb = 2'b01; o.rs = 2'b10; o.br = 1'b1; end
      S_FAULT:    o.flt = 1'b1;
      default:    o.flt = 1'b0;
    endcase
    return o;
  endfunction

  function automatic obs_t observe();
    return {State, IRWrite, NextPC, AdrSrc, RegW, MemW, Branch, ALUOp,
            ALUSrcA, ALUSrcB, ResultSrc, Fault};
  endfunction

  task automatic plan(input int n, input logic rst, input logic [1:0] op, input logic imm,
                      input logic ld, input logic mr, input logic [3:0] st);
    for (int i = 0; i < n; i++) begin
      stim_q.push_back({rst, op, imm, ld, mr});
      exp_q.push_back(moore(st, mr));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; MemReady = 1'b0; Op = 2'b00; Imm = 1'b0; Load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1; MemReady = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1; o = observe(); checks++;
    if (o !== moore(S_FETCH, 1'b0)) begin
      failures++; $display("FAIL reset_idle got=%h exp=%h", o, moore(S_FETCH, 1'b0));
    end
    MemReady = 1'b1;
    #1; o = observe(); checks++;
    if (o !== moore(S_FETCH, 1'b1)) begin
      failures++; $display("FAIL reset_fetch_ready got=%h exp=%h", o, moore(S_FETCH, 1'b1));
    end
  endtask

  task automatic test_dp();
    stim_t s; obs_t e, o; int n = 0;
    do_reset();
    plan(1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, S_FETCH);
    plan(1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, S_DECODE);
    plan(1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, S_EXECR);
    plan(1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, S_ALUWB);
    plan(1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, S_FETCH);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {reset, Op, Imm, Load, MemReady} = s;
      #1; o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL dp cyc%0d got=%h exp=%h", n, o, e); end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    stim_t s; obs_t e, o; int n = 0;
    do_reset();
    plan(1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, S_FETCH);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, S_DECODE);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, S_MEMADR);
    plan(3, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, S_MEMREAD);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, S_MEMREAD);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, S_MEMWB);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, S_FETCH);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {reset, Op, Imm, Load, MemReady} = s;
      #1; o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL load_wait cyc%0d got=%h exp=%h", n, o, e); end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_store_timeout();
    stim_t s; obs_t e, o; int n = 0;
    do_reset();
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, S_FETCH);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, S_DECODE);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, S_MEMADR);
    plan(WAIT_MAX, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, S_MEMWRITE);
    plan(3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, S_FAULT);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {reset, Op, Imm, Load, MemReady} = s;
      #1; o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL store_timeout cyc%0d got=%h exp=%h", n, o, e); end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_wait_edge();
    stim_t s; obs_t e, o; int n = 0;
    do_reset();
    // FETCH ready on its last tolerated cycle, then a store and a load likewise.
    plan(WAIT_MAX - 1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, S_FETCH);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, S_FETCH);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, S_DECODE);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, S_MEMADR);
    plan(WAIT_MAX - 1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, S_MEMWRITE);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, S_MEMWRITE);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, S_FETCH);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, S_DECODE);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, S_MEMADR);
    plan(WAIT_MAX - 1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, S_MEMREAD);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, S_MEMREAD);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, S_MEMWB);
    plan(WAIT_MAX, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, S_FETCH);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, S_FAULT);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {reset, Op, Imm, Load, MemReady} = s;
      #1; o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL wait_edge cyc%0d got=%h exp=%h", n, o, e); end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reserved_op();
    stim_t s; obs_t e, o; int n = 0;
    do_reset();
    plan(1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, S_FETCH);
    plan(1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, S_DECODE);
    plan(10, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, S_FAULT);
    plan(1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, S_FAULT);
    plan(1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, S_FETCH);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {reset, Op, Imm, Load, MemReady} = s;
      #1; o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL reserved_op cyc%0d got=%h exp=%h", n, o, e); end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_write();
    stim_t s; obs_t e, o; int n = 0;
    do_reset();
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, S_FETCH);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, S_DECODE);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, S_MEMADR);
    plan(8, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, S_MEMWRITE);
    plan(1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, S_MEMWRITE);
    // A full fresh wait budget in FETCH proves the count restarted from zero.
    plan(WAIT_MAX - 1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, S_FETCH);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, S_FETCH);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, S_DECODE);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, S_MEMADR);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {reset, Op, Imm, Load, MemReady} = s;
      #1; o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_mid_write cyc%0d got=%h exp=%h", n, o, e); end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s; obs_t e, o; int n = 0;
    do_reset();
    plan(1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, S_FETCH);
    plan(1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, S_DECODE);
    plan(1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, S_BRANCH);
    plan(1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, S_FETCH);
    plan(1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, S_DECODE);
    plan(1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, S_EXECI);
    plan(1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, S_ALUWB);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, S_FETCH);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, S_DECODE);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, S_MEMADR);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, S_MEMWRITE);
    plan(1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, S_FETCH);
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      {reset, Op, Imm, Load, MemReady} = s;
      #1; o = observe(); checks++;
      if (o !== e) begin failures++; $display("FAIL back_to_back cyc%0d got=%h exp=%h", n, o, e); end
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_dp();
    test_load_wait();
    test_store_timeout();
    test_wait_edge();
    test_reserved_op();
    test_reset_mid_write();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
